// File: rtl/ex_pipe_slice.sv
// ex_pipe_slice: MIPS execute slice with ID/EX and EX/MEM registers and the EX/MEM forwarding buses.
module ex_pipe_slice #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic              clk,
    input  logic              Rst_n,
    input  logic [2:0]        stall_i,
    input  logic              flush_i,
    input  logic [7:0]        id_aluop_i,
    input  logic [2:0]        id_alusel_i,
    input  logic [DATA_W-1:0] id_reg1_i,
    input  logic [DATA_W-1:0] id_reg2_i,
    input  logic [ADDR_W-1:0] id_wd_i,
    input  logic              id_wreg_i,
    output logic              ex_wreg_o,
    output logic [DATA_W-1:0] ex_wdata_o,
    output logic [ADDR_W-1:0] ex_wd_o,
    output logic              mem_wreg_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    output logic [ADDR_W-1:0] mem_wd_o
);
    localparam int SA_W = $clog2(DATA_W);
    localparam logic [7:0] EXE_NOP_OP = 8'b0000_0000;
    localparam logic [7:0] EXE_AND_OP = 8'b0010_0100;
    localparam logic [7:0] EXE_OR_OP  = 8'b0010_0101;
    localparam logic [7:0] EXE_XOR_OP = 8'b0010_0110;
    localparam logic [7:0] EXE_NOR_OP = 8'b0010_0111;
    localparam logic [7:0] EXE_SLL_OP = 8'b0111_1100;
    localparam logic [7:0] EXE_SRL_OP = 8'b0000_0010;
    localparam logic [7:0] EXE_SRA_OP = 8'b0000_0011;
    localparam logic [2:0] EXE_RES_NOP   = 3'b000;
    localparam logic [2:0] EXE_RES_LOGIC = 3'b001;
    localparam logic [2:0] EXE_RES_SHIFT = 3'b010;

    logic [7:0]        aluop_q, aluop_d;
    logic [2:0]        alusel_q, alusel_d;
    logic [DATA_W-1:0] reg1_q, reg1_d, reg2_q, reg2_d;
    logic [ADDR_W-1:0] wd_q, wd_d;
    logic              wreg_q, wreg_d;
    logic              mem_wreg_q, mem_wreg_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic [ADDR_W-1:0] mem_wd_q, mem_wd_d;
    logic              idex_clr, idex_ld, exmem_clr, exmem_ld;
    logic [SA_W-1:0]   sa;
    logic [DATA_W-1:0] logic_res, shift_res;

    always_comb begin
        sa        = reg1_q[SA_W-1:0];
        logic_res = aluop_q == EXE_OR_OP  ? reg1_q | reg2_q :
                    aluop_q == EXE_AND_OP ? reg1_q & reg2_q :
                    aluop_q == EXE_XOR_OP ? reg1_q ^ reg2_q :
                    aluop_q == EXE_NOR_OP ? ~(reg1_q | reg2_q) : '0;
        shift_res = aluop_q == EXE_SLL_OP ? reg2_q << sa :
                    aluop_q == EXE_SRL_OP ? reg2_q >> sa :
                    aluop_q == EXE_SRA_OP ? $unsigned($signed(reg2_q) >>> sa) : '0;
        ex_wdata_o = alusel_q == EXE_RES_LOGIC ? logic_res :
                     alusel_q == EXE_RES_SHIFT ? shift_res : '0;
        ex_wreg_o  = wreg_q;
        ex_wd_o    = wd_q;
    end

    // A stage stalled while its successor runs emits a bubble; a stalled successor holds.
    always_comb begin
        idex_clr    = flush_i | (stall_i[0] & ~stall_i[1]);
        idex_ld     = ~stall_i[1];
        exmem_clr   = flush_i | (stall_i[1] & ~stall_i[2]);
        exmem_ld    = ~stall_i[2];
        aluop_d     = idex_clr ? EXE_NOP_OP : idex_ld ? id_aluop_i : aluop_q;
        alusel_d    = idex_clr ? EXE_RES_NOP : idex_ld ? id_alusel_i : alusel_q;
        reg1_d      = idex_clr ? '0 : idex_ld ? id_reg1_i : reg1_q;
        reg2_d      = idex_clr ? '0 : idex_ld ? id_reg2_i : reg2_q;
        wd_d        = idex_clr ? '0 : idex_ld ? id_wd_i : wd_q;
        wreg_d      = idex_clr ? 1'b0 : idex_ld ? id_wreg_i : wreg_q;
        mem_wreg_d  = exmem_clr ? 1'b0 : exmem_ld ? ex_wreg_o : mem_wreg_q;
        mem_wdata_d = exmem_clr ? '0 : exmem_ld ? ex_wdata_o : mem_wdata_q;
        mem_wd_d    = exmem_clr ? '0 : exmem_ld ? ex_wd_o : mem_wd_q;
    end

    always_ff @(posedge clk) begin
        if (Rst_n) begin
            aluop_q     <= EXE_NOP_OP;
            alusel_q    <= EXE_RES_NOP;
            reg1_q      <= '0;
            reg2_q      <= '0;
            wd_q        <= '0;
            wreg_q      <= 1'b0;
            mem_wreg_q  <= 1'b0;
            mem_wdata_q <= '0;
            mem_wd_q    <= '0;
        end else begin
            aluop_q     <= aluop_d;
            alusel_q    <= alusel_d;
            reg1_q      <= reg1_d;
            reg2_q      <= reg2_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            mem_wreg_q  <= mem_wreg_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wd_q    <= mem_wd_d;
        end
    end

    assign mem_wreg_o  = mem_wreg_q;
    assign mem_wdata_o = mem_wdata_q;
    assign mem_wd_o    = mem_wd_q;
endmodule

// File: doc/ex_pipe_slice.md
Name: ex_pipe_slice

Overview:
- Execute slice of the 5-stage MIPS core. It consumes the decoder's outputs (aluop, alusel, operands, write destination) through an internal ID/EX register.
- It computes logic and shift results and drives the EX-stage forwarding bus (ex_wreg/ex_wdata/ex_wd) back into the decoder.
- It also holds the EX/MEM register that drives the MEM-stage forwarding bus (mem_wreg/mem_wdata/mem_wd).
- It is the producer end of the decoder's forwarding interface and the consumer end of its decode interface.

Parameters:
- DATA_W, 32, width of the operand and result datapath (`RegBus).
- ADDR_W, 5, width of the register address (`RegAddrBus).

Ports:
- clk  in  1  rising-edge clock.
- Rst_n  in  1  reset; synchronous, active-high (1 = reset).
- stall_i  in  3  stall vector: [0] ID stalled, [1] EX stalled, [2] MEM stalled.
- flush_i  in  1  synchronous flush of both internal registers.
- id_aluop_i  in  8  `AluOpBus from decoder.
- id_alusel_i  in  3  `AluSelBus from decoder.
- id_reg1_i  in  DATA_W  operand 1 (shift amount source for shifts).
- id_reg2_i  in  DATA_W  operand 2.
- id_wd_i  in  ADDR_W  destination register.
- id_wreg_i  in  1  write enable.
- ex_wreg_o  out  1  EX forwarding: write enable (combinational from ID/EX register).
- ex_wdata_o  out  DATA_W  EX forwarding: result.
- ex_wd_o  out  ADDR_W  EX forwarding: destination.
- mem_wreg_o  out  1  EX/MEM registered write enable.
- mem_wdata_o  out  DATA_W  EX/MEM registered result.
- mem_wd_o  out  ADDR_W  EX/MEM registered destination.

Behaviour:
- Reset (Rst_n=1 at clk edge): ID/EX register = NOP (`EXE_NOP_OP, `EXE_RES_NOP, operands 0, wd `NOPRegAddr, wreg `WriteDisable). EX/MEM register = wreg 0, wdata 0, wd 0.
- Reset value of every output: 0 (ex_* outputs are derived from the cleared ID/EX register). Reset overrides flush_i and stall_i.
- Flush (flush_i=1, no reset): both registers load the reset values on the same edge.
- ID/EX update priority, highest first: reset, flush, then
  - stall_i[0]=1 and stall_i[1]=0: load NOP bubble.
  - stall_i[1]=1: hold.
  - otherwise: load id_* inputs.
- EX/MEM update priority, highest first: reset, flush, then
  - stall_i[1]=1 and stall_i[2]=0: load bubble (wreg 0, wdata 0, wd 0).
  - stall_i[2]=1: hold.
  - otherwise: load the current ex_* values.
- EX compute, combinational from the ID/EX register:
  - Logic: OR a|b; AND a&b; XOR a^b; NOR ~(a|b).
  - Shift: sa = reg1[4:0]. SLL reg2<<sa; SRL reg2>>sa with zero fill; SRA reg2>>>sa with sign fill from reg2[31]. sa=0 returns reg2 unchanged; sa=31 on SRA yields all sign bits.
  - alusel `EXE_RES_LOGIC selects the logic result, `EXE_RES_SHIFT the shift result, any other value gives 0.
  - Unknown aluop within a valid alusel gives 0.
- ex_wreg_o = latched wreg, ex_wd_o = latched wd, ex_wdata_o = selected result.
- Latency: an instruction accepted at edge N appears on ex_* during cycle N+1 and on mem_* after edge N+1, giving 1-cycle and 2-cycle forwarding distances.
- Back-to-back dependent instructions need no bubble: the decoder picks up the result from ex_*.
- A held ID/EX register keeps ex_* stable and re-presents them every cycle.
- Reset mid-stall: reset wins and both registers clear.

Test Plan:
- Reset then one instruction:
  - Stimulus: reset 2 cycles, then OR with reg1=0x0000_FF00, reg2=0x0000_00FF, wd=5, wreg=1.
  - Response: next cycle ex_wdata_o=0x0000_FFFF, ex_wd_o=5, ex_wreg_o=1; one cycle later mem_* carries the same values. All outputs are 0 during reset.
- Logic and shift sweep with reg1=0x0000_0004, reg2=0x8000_00F0:
  - SLL gives 0x0000_0F00.
  - SRL gives 0x0800_000F.
  - SRA gives 0xF800_000F.
  - NOR of reg1=0, reg2=0 gives 0xFFFF_FFFF.
- stall_i=3'b001 for one cycle while a valid instruction is presented: ID/EX takes a bubble, so ex_wreg_o=0 next cycle and mem_wreg_o=0 the cycle after.
- stall_i=3'b011 for 2 cycles with XOR of 0xAAAA_AAAA and 0x5555_5555 already in ID/EX: ex_wdata_o holds 0xFFFF_FFFF for both cycles, and EX/MEM takes bubbles (mem_wreg_o=0).
- stall_i=3'b111: both registers hold. mem_* is unchanged across the stall, and resumes advancing when stall_i returns to 0.
- Mid-stall events:
  - Assert flush_i during stall_i=3'b111: both registers clear and all outputs are 0 next cycle.
  - Assert Rst_n=1 mid-stall: all outputs are 0 next cycle.
